// File: rtl/pe_result_collector.sv
// Collects per-PE match results for one search job into a packed vector, presented to the
// result comparator through a valid/acknowledge handshake. Optional macro: PE_COLLECT_TIMEOUT_EN.
module pe_result_collector #(
   parameter int unsigned NUM_PE      = 8,
   parameter int unsigned MAX_STR_ADD = 5,
   parameter int unsigned TIMEOUT_CYC = 255
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic                                 start,
   input  logic [NUM_PE-1:0]                    pe_done,
   input  logic [NUM_PE-1:0]                    pe_match,
   input  logic [NUM_PE*MAX_STR_ADD-1:0]        pe_addr,
   output logic [NUM_PE*(MAX_STR_ADD+1)-1:0]    pe_result,
   output logic                                 o_valid,
   input  logic                                 cmp_valid,
   output logic [NUM_PE-1:0]                    pe_pending,
   output logic                                 busy,
   output logic                                 timed_out
);

   localparam int unsigned SLOT_W      = MAX_STR_ADD + 1;
   localparam int unsigned RES_W       = NUM_PE * SLOT_W;
   localparam logic [7:0]  TIMEOUT_VAL = 8'(TIMEOUT_CYC);

   typedef enum logic [1:0] {StIdle, StCollect, StSend, StRelease} state_e;

   state_e              state_q, state_d;
   logic [RES_W-1:0]    result_q, result_d;
   logic [NUM_PE-1:0]   pending_q, pending_d;
   logic                expire;

`ifdef PE_COLLECT_TIMEOUT_EN
   logic [7:0] cnt_q, cnt_d;
   logic       timed_out_q, timed_out_d;

   always_comb begin
      cnt_d = cnt_q;
      if (state_q == StIdle && start) begin
         cnt_d = '0;
      end else if (state_q == StCollect) begin
         cnt_d = cnt_q + 8'd1;
      end
   end

   // Only a genuine shortfall counts as a timeout; a job completing on the expiry cycle does not.
   assign expire = (state_q == StCollect) && (cnt_q == TIMEOUT_VAL) && (pending_d != '0);

   always_comb begin
      timed_out_d = timed_out_q;
      if (state_q == StIdle && start) begin
         timed_out_d = 1'b0;
      end else if (expire) begin
         timed_out_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt_q       <= '0;
         timed_out_q <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         timed_out_q <= timed_out_d;
      end
   end

   assign timed_out = timed_out_q;
`else
   logic unused_timeout;
   assign unused_timeout = ^TIMEOUT_VAL;
   assign expire         = 1'b0;
   assign timed_out      = 1'b0;
`endif

   // Misses are all-ones so an unsigned minimum search prefers any match.
   always_comb begin
      result_d  = result_q;
      pending_d = pending_q;
      case (state_q)
         StIdle: begin
            if (start) begin
               result_d  = '1;
               pending_d = '1;
            end
         end
         StCollect: begin
            for (int i = 0; i < NUM_PE; i++) begin
               if (pe_done[i] && pending_q[i]) begin
                  result_d[i*SLOT_W +: SLOT_W] = pe_match[i] ?
                        {1'b0, pe_addr[i*MAX_STR_ADD +: MAX_STR_ADD]} : {SLOT_W{1'b1}};
                  pending_d[i] = 1'b0;
               end
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:    if (start) state_d = StCollect;
         StCollect: if (pending_d == '0 || expire) state_d = StSend;
         StSend:    if (cmp_valid) state_d = StRelease;
         StRelease: if (!cmp_valid) state_d = StIdle;
         default:   state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         result_q  <= '0;
         pending_q <= '0;
      end else begin
         result_q  <= result_d;
         pending_q <= pending_d;
      end
   end

   always_comb begin
      o_valid    = (state_q == StSend);
      busy       = (state_q != StIdle);
      pe_result  = result_q;
      pe_pending = pending_q;
   end

endmodule

// File: tb/tb_pe_result_collector.sv
// Directed, table-driven bench for pe_result_collector (NUM_PE=4, MAX_STR_ADD=4).
module tb_pe_result_collector;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [3:0]  pe_done;
   logic [3:0]  pe_match;
   logic [15:0] pe_addr;
   logic [19:0] pe_result;
   logic        o_valid;
   logic        cmp_valid;
   logic [3:0]  pe_pending;
   logic        busy;
   logic        timed_out;

   int errors = 0;
   int checks = 0;

   pe_result_collector #(
      .NUM_PE      (4),
      .MAX_STR_ADD (4),
      .TIMEOUT_CYC (10)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .pe_done    (pe_done),
      .pe_match   (pe_match),
      .pe_addr    (pe_addr),
      .pe_result  (pe_result),
      .o_valid    (o_valid),
      .cmp_valid  (cmp_valid),
      .pe_pending (pe_pending),
      .busy       (busy),
      .timed_out  (timed_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst_n;
      logic        start;
      logic [3:0]  done;
      logic [3:0]  match;
      logic [15:0] addr;
      logic        cmp;
      logic [19:0] exp_res;
      logic        exp_valid;
      logic [3:0]  exp_pend;
      logic        exp_busy;
   } vec_t;

   localparam logic [4:0] M = 5'b11111;
   localparam int NV = 26;
   vec_t vecs[NV];

   function automatic vec_t mk(logic r, logic s, logic [3:0] d, logic [3:0] m, logic [15:0] a,
                               logic c, logic [19:0] er, logic ev, logic [3:0] ep, logic eb);
      vec_t v;
      v.rst_n = r; v.start = s; v.done = d; v.match = m; v.addr = a; v.cmp = c;
      v.exp_res = er; v.exp_valid = ev; v.exp_pend = ep; v.exp_busy = eb;
      return v;
   endfunction

   task automatic step(logic r, logic s, logic [3:0] d, logic [3:0] m, logic [15:0] a, logic c);
      reset = r; start = s; pe_done = d; pe_match = m; pe_addr = a; cmp_valid = c;
      @(posedge clk);
      #1;
   endtask

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic check_all(string tag, logic [19:0] er, logic ev, logic [3:0] ep, logic eb,
                            logic et);
      check({tag, " pe_result"}, 32'(pe_result), 32'(er));
      check({tag, " o_valid"}, 32'(o_valid), 32'(ev));
      check({tag, " pe_pending"}, 32'(pe_pending), 32'(ep));
      check({tag, " busy"}, 32'(busy), 32'(eb));
      check({tag, " timed_out"}, 32'(timed_out), 32'(et));
   endtask

   initial begin
      logic [19:0] stag, simul, dup;
      stag  = {5'b01001, 5'b00001, 5'b00111, 5'b00011};
      simul = {5'b00010, M, 5'b00110, 5'b00000};
      dup   = {M, M, 5'b00100, M};

      // reset with start held, then staggered job
      vecs[0]  = mk(0, 1, 4'b0000, 4'b0000, 16'h0000, 0, 20'h0,    0, 4'b0000, 0);
      vecs[1]  = mk(0, 1, 4'b0000, 4'b0000, 16'h0000, 0, 20'h0,    0, 4'b0000, 0);
      vecs[2]  = mk(1, 1, 4'b0000, 4'b0000, 16'h0000, 0, '1,       0, 4'b1111, 1);
      vecs[3]  = mk(1, 0, 4'b0001, 4'b0001, 16'h0003, 0, {M, M, M, 5'b00011}, 0, 4'b1110, 1);
      vecs[4]  = mk(1, 0, 4'b0010, 4'b0010, 16'h0070, 0, {M, M, 5'b00111, 5'b00011}, 0, 4'b1100, 1);
      vecs[5]  = mk(1, 0, 4'b0100, 4'b0100, 16'h0100, 0, {M, 5'b00001, 5'b00111, 5'b00011}, 0,
                    4'b1000, 1);
      vecs[6]  = mk(1, 0, 4'b1000, 4'b1000, 16'h9000, 0, stag,     1, 4'b0000, 1);
      // done pulses in SEND are ignored; cmp_valid rises 3 cycles after o_valid
      vecs[7]  = mk(1, 0, 4'b1111, 4'b1111, 16'h0000, 0, stag,     1, 4'b0000, 1);
      vecs[8]  = mk(1, 0, 4'b0000, 4'b0000, 16'h0000, 0, stag,     1, 4'b0000, 1);
      vecs[9]  = mk(1, 0, 4'b0000, 4'b0000, 16'h0000, 1, stag,     0, 4'b0000, 1);
      vecs[10] = mk(1, 1, 4'b0000, 4'b0000, 16'h0000, 1, stag,     0, 4'b0000, 1);
      vecs[11] = mk(1, 1, 4'b0000, 4'b0000, 16'h0000, 0, stag,     0, 4'b0000, 0);
      vecs[12] = mk(1, 1, 4'b0000, 4'b0000, 16'h0000, 0, '1,       0, 4'b1111, 1);
      // simultaneous capture with PE2 missing
      vecs[13] = mk(1, 0, 4'b1111, 4'b1011, 16'h2560, 0, simul,    1, 4'b0000, 1);
      vecs[14] = mk(1, 0, 4'b0000, 4'b0000, 16'h0000, 1, simul,    0, 4'b0000, 1);
      vecs[15] = mk(1, 0, 4'b0000, 4'b0000, 16'h0000, 0, simul,    0, 4'b0000, 0);
      // duplicate done: first capture wins
      vecs[16] = mk(1, 1, 4'b0000, 4'b0000, 16'h0000, 0, '1,       0, 4'b1111, 1);
      vecs[17] = mk(1, 0, 4'b0010, 4'b0010, 16'h0040, 0, {M, M, 5'b00100, M}, 0, 4'b1101, 1);
      vecs[18] = mk(1, 0, 4'b0010, 4'b0010, 16'h0020, 0, {M, M, 5'b00100, M}, 0, 4'b1101, 1);
      vecs[19] = mk(1, 0, 4'b1101, 4'b0000, 16'h0000, 0, dup,      1, 4'b0000, 1);
      vecs[20] = mk(1, 0, 4'b1111, 4'b1111, 16'h0000, 1, dup,      0, 4'b0000, 1);
      vecs[21] = mk(1, 0, 4'b0000, 4'b0000, 16'h0000, 0, dup,      0, 4'b0000, 0);
      // reset mid-job
      vecs[22] = mk(1, 1, 4'b0000, 4'b0000, 16'h0000, 0, '1,       0, 4'b1111, 1);
      vecs[23] = mk(1, 0, 4'b0001, 4'b0001, 16'h0005, 0, {M, M, M, 5'b00101}, 0, 4'b1110, 1);
      vecs[24] = mk(0, 0, 4'b0000, 4'b0000, 16'h0000, 0, 20'h0,    0, 4'b0000, 0);
      vecs[25] = mk(1, 0, 4'b0000, 4'b0000, 16'h0000, 0, 20'h0,    0, 4'b0000, 0);

      reset = 0; start = 0; pe_done = '0; pe_match = '0; pe_addr = '0; cmp_valid = 0;

      for (int i = 0; i < NV; i++) begin
         step(vecs[i].rst_n, vecs[i].start, vecs[i].done, vecs[i].match, vecs[i].addr, vecs[i].cmp);
         check_all($sformatf("vec%0d", i), vecs[i].exp_res, vecs[i].exp_valid, vecs[i].exp_pend,
                   vecs[i].exp_busy, 1'b0);
      end

      // stale cmp_valid high on SEND entry: SEND lasts exactly one cycle
      step(1, 1, 4'b0000, 4'b0000, 16'h0000, 1);
      step(1, 0, 4'b1111, 4'b1111, 16'h1234, 1);
      check_all("stale send", {5'b00001, 5'b00010, 5'b00011, 5'b00100}, 1, 4'b0000, 1, 0);
      step(1, 0, 4'b0000, 4'b0000, 16'h0000, 1);
      check_all("stale release", {5'b00001, 5'b00010, 5'b00011, 5'b00100}, 0, 4'b0000, 1, 0);
      step(1, 0, 4'b0000, 4'b0000, 16'h0000, 0);
      check("stale idle busy", 32'(busy), 32'd0);

      // only PE0 finishes
      step(1, 1, 4'b0000, 4'b0000, 16'h0000, 0);
      step(1, 0, 4'b0001, 4'b0001, 16'h0005, 0);
      for (int j = 2; j <= 10; j++) step(1, 0, 4'b0000, 4'b0000, 16'h0000, 0);
      check_all("pre-expiry", {M, M, M, 5'b00101}, 0, 4'b1110, 1, 0);
      step(1, 0, 4'b0000, 4'b0000, 16'h0000, 0);
`ifdef PE_COLLECT_TIMEOUT_EN
      check("timeout o_valid", 32'(o_valid), 32'd1);
      check("timeout timed_out", 32'(timed_out), 32'd1);
      check("timeout pe_result", 32'(pe_result), 32'({M, M, M, 5'b00101}));
      step(1, 0, 4'b0000, 4'b0000, 16'h0000, 1);
      step(1, 0, 4'b0000, 4'b0000, 16'h0000, 0);
      check("timeout sticky", 32'(timed_out), 32'd1);
      step(1, 1, 4'b0000, 4'b0000, 16'h0000, 0);
      check("timeout cleared", 32'(timed_out), 32'd0);
`else
      for (int j = 0; j < 20; j++) step(1, 0, 4'b0000, 4'b0000, 16'h0000, 0);
      check_all("no timeout wait", {M, M, M, 5'b00101}, 0, 4'b1110, 1, 0);
      step(1, 0, 4'b1110, 4'b0100, 16'h0300, 0);
      check_all("late finish", {M, 5'b00011, M, 5'b00101}, 1, 4'b0000, 1, 0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pe_result_collector.md
# pe_result_collector

Gathers per-PE match results for one search job and presents them as a single packed result vector with a valid/acknowledge handshake to the PE result comparator. Sits between the PE array and the comparator. It captures each PE's asynchronous-in-time done pulse into a slot, and asserts `o_valid` once every slot is filled. It holds the vector stable until the comparator has loaded it and reported completion.

## Interface
Parameters:
- `NUM_PE`, default 8: number of PEs and result slots; power of two, ≥2.
- `MAX_STR_ADD`, default 5: match-address width; slot width is `MAX_STR_ADD+1`.
- `TIMEOUT_CYC`, default 255: COLLECT-cycle limit; used only with the timeout macro; 8-bit counter.

Ports:
- `clk`, in, 1: clock; all logic on the rising edge.
- `reset`, in, 1: synchronous, active-low reset.
- `start`, in, 1: begin a new job; honoured only in IDLE.
- `pe_done`, in, `NUM_PE`: per-PE one-cycle done pulse.
- `pe_match`, in, `NUM_PE`: per-PE match flag; qualified by `pe_done`.
- `pe_addr`, in, `NUM_PE*MAX_STR_ADD`: per-PE match address; PE i occupies bits `[i*MAX_STR_ADD +: MAX_STR_ADD]`.
- `pe_result`, out, `NUM_PE*(MAX_STR_ADD+1)`: packed slots.
  - Slot i occupies bits `[i*(MAX_STR_ADD+1) +: MAX_STR_ADD+1]`.
  - Slot format is `{miss, addr}`.
- `o_valid`, out, 1: result vector valid; drives the comparator `i_valid`.
- `cmp_valid`, in, 1: comparator `o_valid`; used as the acknowledge.
- `pe_pending`, out, `NUM_PE`: 1 marks a slot not yet filled in the current job.
- `busy`, out, 1: high whenever the state is not IDLE.
- `timed_out`, out, 1: the last job was sent by timeout; constant 0 when the macro is absent.

## Operation
State machine with four states:
- **IDLE**:
  - When `start`=1: load every slot with all-ones (miss=1, addr=all-ones), set `pe_pending` to all-ones, clear `timed_out`, and go to COLLECT.
- **COLLECT**:
  - For each i with `pe_done[i]`=1 and `pe_pending[i]`=1: slot i ← `{~pe_match[i], pe_match[i] ? addr_i : all-ones}`, and clear `pe_pending[i]`.
  - Any number of PEs may be captured in the same cycle.
  - When no pending bits remain after the current cycle's captures, go to SEND.
- **SEND**:
  - `o_valid`=1.
  - When `cmp_valid`=1, go to RELEASE.
- **RELEASE**:
  - `o_valid`=0.
  - When `cmp_valid`=0, go to IDLE.
- `pe_result` is held constant from the last capture until the next honoured `start`.

Miss encoding: a no-match slot is always all-ones, so an unsigned minimum search always prefers matches, and among matches the lowest address.

Boundary rules:
- Duplicate `pe_done` for an already-filled slot is ignored; the first capture wins.
- `pe_done` outside COLLECT is ignored.
- `start` outside IDLE is ignored.
- `start` on the same cycle as entry into IDLE is not honoured until the following cycle.
- `cmp_valid` high on entry to SEND (stale) is allowed: SEND lasts one cycle, then RELEASE.
- Reset (`reset`=0) in any state: the state goes to IDLE and all outputs clear on the next edge, mid-job included.

## Timing
Reset values: `pe_result`=0, `o_valid`=0, `pe_pending`=0, `busy`=0, `timed_out`=0.

Latencies and handshake:
- `start` sampled at edge N gives COLLECT, `busy`=1 and `pe_pending`=all-ones from N+1.
- The last capture at edge M gives `o_valid`=1 from M+1. Minimum latency is therefore 2 cycles from `start`, when all PEs complete at N+1.
- `o_valid` is held with no upper bound until `cmp_valid`=1 is sampled, then drops on the next edge.
- After `o_valid` drops, `busy` remains high until `cmp_valid`=0 is sampled. The next `start` is accepted one cycle later.
- The comparator loads `pe_result` one cycle after `i_valid` rises. The vector is stable throughout SEND and RELEASE.

## Configuration
Macro: `PE_COLLECT_TIMEOUT_EN`.
- Defined:
  - An 8-bit counter clears on COLLECT entry and increments on each COLLECT cycle.
  - When it equals `TIMEOUT_CYC` with pending slots remaining, the block goes to SEND on the next edge.
  - Unfilled slots stay all-ones (miss), and `timed_out` is set to 1 until the next honoured `start`.
  - Captures on the expiry cycle still take effect.
- Undefined: no counter is built; COLLECT waits indefinitely and `timed_out` is tied to 0.

## Test plan
Common settings: `NUM_PE`=4, `MAX_STR_ADD`=4, 5-bit slots; `pe_result` values below are listed as slots 3,2,1,0.
- Reset: hold `reset`=0 for 2 cycles with `start`=1 -> all outputs 0 and state IDLE; after `reset`=1, `start` -> `busy`=1 next cycle.
- Staggered completion: `start`, then PEs 0,1,2,3 done on consecutive cycles with matches at addresses 3,7,1,9 -> `o_valid`=1 one cycle after PE3 done, `pe_result`={01001,00001,00111,00011}.
- Simultaneous capture plus miss: all four `pe_done` in one cycle, PE2 with `pe_match`=0 -> slot2=11111 and `o_valid` the next cycle.
- Duplicate done: PE1 done with addr 4, later done again with addr 2 -> slot1=00100.
- Handshake: `cmp_valid` rises 3 cycles after `o_valid` -> `o_valid` low the next cycle; `busy` stays 1 until `cmp_valid`=0; a `start` pulse in RELEASE is ignored.
- Timeout: macro defined, `TIMEOUT_CYC`=10, only PE0 done (addr 5) -> `o_valid` after the counter reaches 10, `timed_out`=1, `pe_result`={11111,11111,11111,00101}.
